// File: rtl/fpu_mult_core.sv
// rtl/fpu_mult_core.sv - IEEE 754 single-precision multiplier core with strobe/ack handshakes
// Build option: define FPU_DENORM_EN for full subnormal support; otherwise subnormals flush to zero.
module fpu_mult_core #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_stb,
  output logic        input_ack,
  output logic [31:0] output_z,
  output logic        output_stb,
  input  logic        output_ack
);

  typedef enum logic [3:0] {
    GET_INPUT,
    UNPACK,
    SPECIAL,
    NORM_A,
    NORM_B,
    MULT_0,
    MULT_1,
    NORM_1,
    NORM_2,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  // Unbiased exponents live in a signed 10-bit range wide enough for
  // normalised subnormal operands (-149) and product overflow (+255).
  localparam logic signed [9:0] EMIN    = -10'sd126;
  localparam logic signed [9:0] EMIN_M1 = -10'sd127;
  localparam logic signed [9:0] EMAX    = 10'sd127;

  state_t            state;
  logic [31:0]       a, b;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              z_s;
  logic [47:0]       product;
  logic              guard, round_bit, sticky;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]  exp_field;
  logic [31:0] pack_z;

  // Operand classification straight from the latched encodings.
  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FPU_DENORM_EN
  assign a_zero = (a[30:23] == 8'h00) && (a[22:0] == 23'd0);
  assign b_zero = (b[30:23] == 8'h00) && (b[22:0] == 23'd0);
`else
  // Flush-to-zero: any subnormal operand behaves as a signed zero.
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
`endif

  assign exp_field = z_e[7:0] + 8'd127;

  // Final encoding: overflow saturates to infinity, exponent -126 without
  // the hidden bit encodes as a subnormal.
  always_comb begin
    pack_z = {z_s, exp_field, z_m[22:0]};
    if ((z_e == EMIN) && !z_m[23])
      pack_z[30:23] = 8'h00;
    if (z_e > EMAX)
      pack_z = {z_s, 8'hFF, 23'd0};
  end

  // Multi-cycle multiply sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GET_INPUT;
      input_ack  <= 1'b1;
      output_stb <= 1'b0;
      output_z   <= 32'd0;
      a          <= 32'd0;
      b          <= 32'd0;
      a_m        <= 24'd0;
      b_m        <= 24'd0;
      z_m        <= 24'd0;
      a_e        <= 10'sd0;
      b_e        <= 10'sd0;
      z_e        <= 10'sd0;
      z_s        <= 1'b0;
      product    <= 48'd0;
      guard      <= 1'b0;
      round_bit  <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      case (state)
        GET_INPUT: begin
          if (input_stb && input_ack) begin
            a         <= input_a;
            b         <= input_b;
            input_ack <= 1'b0;
            state     <= UNPACK;
          end
        end

        UNPACK: begin
          if (a[30:23] == 8'h00) begin
            a_e <= EMIN;
            a_m <= {1'b0, a[22:0]};
          end else begin
            a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
            a_m <= {1'b1, a[22:0]};
          end
          if (b[30:23] == 8'h00) begin
            b_e <= EMIN;
            b_m <= {1'b0, b[22:0]};
          end else begin
            b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
            b_m <= {1'b1, b[22:0]};
          end
          state <= SPECIAL;
        end

        SPECIAL: begin
          if (a_nan || b_nan) begin
            output_z   <= NAN_VALUE;
            output_stb <= 1'b1;
            state      <= PUT_Z;
          end else if (a_inf || b_inf) begin
            if (a_zero || b_zero)
              output_z <= NAN_VALUE;
            else
              output_z <= {a[31] ^ b[31], 8'hFF, 23'd0};
            output_stb <= 1'b1;
            state      <= PUT_Z;
          end else if (a_zero || b_zero) begin
            output_z   <= {a[31] ^ b[31], 31'd0};
            output_stb <= 1'b1;
            state      <= PUT_Z;
          end else begin
            state <= NORM_A;
          end
        end

        // Leave in the same cycle as the shift that sets the hidden bit.
        NORM_A: begin
          if (!a_m[23]) begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
            if (a_m[22])
              state <= NORM_B;
          end else begin
            state <= NORM_B;
          end
        end

        NORM_B: begin
          if (!b_m[23]) begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
            if (b_m[22])
              state <= MULT_0;
          end else begin
            state <= MULT_0;
          end
        end

        MULT_0: begin
          z_s     <= a[31] ^ b[31];
          z_e     <= a_e + b_e + 10'sd1;
          product <= {24'd0, a_m} * {24'd0, b_m};
          state   <= MULT_1;
        end

        MULT_1: begin
          z_m       <= product[47:24];
          guard     <= product[23];
          round_bit <= product[22];
          sticky    <= |product[21:0];
          state     <= NORM_1;
        end

        // Product of two normalised mantissas needs at most one left shift.
        NORM_1: begin
          if (!z_m[23]) begin
            z_e       <= z_e - 10'sd1;
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            if (z_m[22])
              state <= NORM_2;
          end else begin
            state <= NORM_2;
          end
        end

`ifdef FPU_DENORM_EN
        // Denormalise toward exponent -126, folding shifted-out bits into sticky.
        NORM_2: begin
          if (z_e < EMIN) begin
            z_e       <= z_e + 10'sd1;
            z_m       <= {1'b0, z_m[23:1]};
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
            if (z_e == EMIN_M1)
              state <= ROUND;
          end else begin
            state <= ROUND;
          end
        end
`else
        // Tiny results become signed zero in one pass-through cycle.
        NORM_2: begin
          if (z_e < EMIN) begin
            z_e       <= EMIN;
            z_m       <= 24'd0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
          end
          state <= ROUND;
        end
`endif

        ROUND: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            if (z_m == 24'hFF_FFFF) begin
              z_m <= 24'h80_0000;
              z_e <= z_e + 10'sd1;
            end else begin
              z_m <= z_m + 24'd1;
            end
          end
          state <= PACK;
        end

        PACK: begin
          output_z   <= pack_z;
          output_stb <= 1'b1;
          state      <= PUT_Z;
        end

        PUT_Z: begin
          if (output_stb && output_ack) begin
            output_stb <= 1'b0;
            input_ack  <= 1'b1;
            state      <= GET_INPUT;
          end
        end

        default: begin
          state      <= GET_INPUT;
          input_ack  <= 1'b1;
          output_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule
